// File: rtl/latch_write_arbiter.sv
// Round-robin write controller for a single shared D-latch.
// Grants one requester, then sequences the latch gate through SETUP/OPEN/HOLD and acks in DONE.
module latch_write_arbiter #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*DATA_W-1:0]   wdata,
  output logic [N_REQ-1:0]          gnt,
  output logic [N_REQ-1:0]          ack,
  output logic [$clog2(N_REQ)-1:0]  owner,
  output logic                      busy,
  output logic                      latch_en,
  output logic [DATA_W-1:0]         latch_d
);

  localparam int unsigned OW = $clog2(N_REQ);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [N_REQ-1:0]    gnt_q, gnt_d;
  logic [N_REQ-1:0]    ack_q, ack_d;
  logic [OW-1:0]       owner_q, owner_d;
  logic [OW-1:0]       ptr_q, ptr_d;
  logic                busy_q, busy_d;
  logic                latch_en_q, latch_en_d;
  logic [DATA_W-1:0]   latch_d_q, latch_d_d;

  logic [OW-1:0]       win_c;
  logic                win_vld_c;
  logic [OW-1:0]       cand_c;
  logic [DATA_W-1:0]   win_data_c;

  // First pending request at or above ptr, wrapping modulo N_REQ.
  always_comb begin
    win_c     = '0;
    win_vld_c = 1'b0;
    cand_c    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand_c = OW'((32'(ptr_q) + k) % N_REQ);
      if (!win_vld_c && req[cand_c]) begin
        win_vld_c = 1'b1;
        win_c     = cand_c;
      end
    end
  end

  always_comb begin
    win_data_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c == OW'(i)) win_data_c = wdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = '0;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    latch_d_d = latch_d_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld_c) begin
          state_d   = SETUP;
          gnt_d     = N_REQ'(1) << win_c;
          owner_d   = win_c;
          latch_d_d = win_data_c;
        end
      end
      SETUP: state_d = OPEN;
      OPEN:  state_d = HOLD;
      HOLD: begin
        state_d = DONE;
        ack_d   = gnt_q;
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Status outputs are registered, so they follow the next state.
    busy_d     = (state_d != IDLE);
    latch_en_d = (state_d == OPEN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      busy_q     <= 1'b0;
      latch_en_q <= 1'b0;
      latch_d_q  <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      latch_en_q <= latch_en_d;
      latch_d_q  <= latch_d_d;
    end
  end

  assign gnt      = gnt_q;
  assign ack      = ack_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign latch_en = latch_en_q;
  assign latch_d  = latch_d_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed self-checking bench for latch_write_arbiter (N_REQ=4, DATA_W=8).
module tb_latch_write_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic [1:0]  owner;
  logic        busy;
  logic        latch_en;
  logic [7:0]  latch_d;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int en_cnt = 0;
  int last_ack_cyc = 0;
  int prev_ack_cyc = 0;
  int en_base;

  latch_write_arbiter #(.N_REQ(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .gnt(gnt), .ack(ack), .owner(owner), .busy(busy),
    .latch_en(latch_en), .latch_d(latch_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Cycle-level invariants and latch-gate / ack bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
      check("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      check("ack_in_gnt", 32'(ack & ~gnt), 32'd0);
      if (latch_en) en_cnt++;
      if (|ack) begin
        prev_ack_cyc = last_ack_cyc;
        last_ack_cyc = cyc;
      end
    end
  end

  // Full five-cycle transaction starting from IDLE with req already applied.
  task automatic txn(input int o, input logic [7:0] d, input bit drop);
    logic [3:0] oh;
    oh = 4'b0001 << o;
    step();
    check("setup_gnt", 32'(gnt), 32'(oh));
    check("setup_owner", 32'(owner), 32'(o));
    check("setup_latch_d", 32'(latch_d), 32'(d));
    check("setup_busy", 32'(busy), 32'd1);
    check("setup_en", 32'(latch_en), 32'd0);
    step();
    check("open_en", 32'(latch_en), 32'd1);
    check("open_latch_d", 32'(latch_d), 32'(d));
    check("open_ack", 32'(ack), 32'd0);
    step();
    check("hold_en", 32'(latch_en), 32'd0);
    check("hold_latch_d", 32'(latch_d), 32'(d));
    step();
    check("done_ack", 32'(ack), 32'(oh));
    check("done_gnt", 32'(gnt), 32'(oh));
    check("done_en", 32'(latch_en), 32'd0);
    if (drop) req[o] = 1'b0;
    step();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt", 32'(gnt), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_latch_d", 32'(latch_d), 32'(d));
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    wdata = 32'h0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(latch_en), 32'd0);
    check("rst_latch_d", 32'(latch_d), 32'd0);

    // Single request
    reset = 1'b0;
    wdata[7:0] = 8'hA5;
    req = 4'b0001;
    txn(0, 8'hA5, 1'b1);

    // All four requesting from ptr=0
    reset = 1'b1;
    step();
    reset = 1'b0;
    wdata = 32'h40302010;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      txn(k, 8'((k + 1) * 16), 1'b1);
      if (k > 0) check("ack_spacing", 32'(last_ack_cyc - prev_ack_cyc), 32'd5);
    end

    // Round-robin fairness: after owner 2, 1001 serves 3 then 0
    wdata[23:16] = 8'h3C;
    req = 4'b0100;
    txn(2, 8'h3C, 1'b1);
    wdata[31:24] = 8'hD3;
    wdata[7:0]   = 8'hD0;
    req = 4'b1001;
    txn(3, 8'hD3, 1'b1);
    txn(0, 8'hD0, 1'b1);

    // Request dropped and data changed during OPEN
    wdata[15:8] = 8'h55;
    req = 4'b0010;
    step();
    check("mid_gnt", 32'(gnt), 32'h2);
    check("mid_latch_d", 32'(latch_d), 32'h55);
    step();
    check("mid_open_en", 32'(latch_en), 32'd1);
    req = 4'b0000;
    wdata[15:8] = 8'hFF;
    step();
    check("mid_hold_latch_d", 32'(latch_d), 32'h55);
    step();
    check("mid_done_ack", 32'(ack), 32'h2);
    check("mid_done_latch_d", 32'(latch_d), 32'h55);
    step();
    check("mid_idle_busy", 32'(busy), 32'd0);
    check("mid_idle_latch_d", 32'(latch_d), 32'h55);

    // Reset during OPEN (ptr=2, so 1010 first grants 3)
    wdata[31:24] = 8'h33;
    wdata[15:8]  = 8'h11;
    req = 4'b1010;
    step();
    check("rso_owner", 32'(owner), 32'd3);
    check("rso_latch_d", 32'(latch_d), 32'h33);
    step();
    check("rso_open_en", 32'(latch_en), 32'd1);
    reset = 1'b1;
    step();
    check("rso_en", 32'(latch_en), 32'd0);
    check("rso_gnt", 32'(gnt), 32'd0);
    check("rso_busy", 32'(busy), 32'd0);
    check("rso_latch_d", 32'(latch_d), 32'd0);
    check("rso_ack", 32'(ack), 32'd0);
    check("rso_owner0", 32'(owner), 32'd0);
    reset = 1'b0;
    txn(1, 8'h11, 1'b1);
    txn(3, 8'h33, 1'b1);

    // Persistent requester 0 alongside requester 2
    wdata[7:0]   = 8'h0A;
    wdata[23:16] = 8'h2A;
    req = 4'b0101;
    en_base = en_cnt;
    txn(0, 8'h0A, 1'b0);
    txn(2, 8'h2A, 1'b0);
    txn(0, 8'h0A, 1'b0);
    txn(2, 8'h2A, 1'b0);
    req = 4'b0000;
    step();
    check("persist_en_pulses", 32'(en_cnt - en_base), 32'd4);
    check("final_busy", 32'(busy), 32'd0);
    check("final_latch_d", 32'(latch_d), 32'h2A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
